unary_expander: RTL and testbench
=================================

Name: unary_expander

Overview:
- Inverse of the population-count stage in the binarized datapath: accepts a count and expands it into a thermometer-coded bit vector whose popcount equals the count.
- The vector is presented two ways: as a registered parallel word, and as a serial bit stream with a valid/ready handshake.
- Sits on the test and stimulus side of the BNN layer. It regenerates activation vectors from counts, and its serial stream drives bit-serial neuron inputs.
- Round-trip invariant: popcount(expanded vector) == clamped count.

Parameters:
- INPUTS, 8, vector length in bits; range 2..16.
- COUNTER_BITS, 4, count width; must satisfy 2^COUNTER_BITS > INPUTS.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- count  input  COUNTER_BITS  count to expand.
- count_valid  input  1  count is presented.
- count_ready  output  1  block can accept a count; asserted only in IDLE.
- bit_out  output  1  current serial bit.
- bit_valid  output  1  bit_out is valid; asserted only in EMIT.
- bit_ready  input  1  consumer accepts bit_out.
- bit_last  output  1  bit_out is bit INPUTS-1 of the vector.
- thermo  output  INPUTS  registered thermometer word of the last accepted count.
- overflow  output  1  last accepted count exceeded INPUTS and was clamped.

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-high, named reset.
- Reset:
  - State goes to IDLE; idx=0, n=0.
  - thermo=0, overflow=0, bit_valid=0, bit_out=0, bit_last=0.
  - count_ready=0 while reset is high, and 1 the first cycle after reset deasserts.
- FSM states: IDLE, EMIT.
- IDLE:
  - count_ready=1.
  - On count_valid&count_ready: n <= min(count, INPUTS).
  - thermo[i] <= (i < n_clamped) for every i.
  - overflow <= (count > INPUTS).
  - idx <= 0; go to EMIT.
  - Accept latency: thermo, overflow and the first bit_valid are all visible the cycle after the accept.
- EMIT:
  - count_ready=0, bit_valid=1.
  - bit_out = (idx < n). Bits are emitted LSB first, so the ones come first.
  - bit_last = (idx == INPUTS-1).
  - On bit_valid&bit_ready: idx <= idx+1. If bit_last, idx <= 0 and go to IDLE.
  - Without bit_ready, bit_out, bit_last and idx hold (stall of arbitrary length).
- Stability rules:
  - bit_out and bit_last depend only on registered state; there is no combinational path from bit_ready or count.
  - count_valid is ignored while in EMIT.
- Throughput: INPUTS accepted bits plus one IDLE cycle per count. Back-to-back vectors therefore take INPUTS+1 cycles each with bit_ready held high.
- Boundary conditions:
  - count=0: all INPUTS bits are 0, thermo=0.
  - count=INPUTS: all bits are 1, overflow=0.
  - count>INPUTS (e.g. 13 with INPUTS=8): clamped to INPUTS, overflow=1.
  - thermo and overflow hold until the next accept; they are not cleared on leaving EMIT.
  - Reset mid-EMIT aborts the vector immediately: bit_valid=0 on the next cycle and no partial bit_last is ever produced.
- Width: idx and n use COUNTER_BITS bits. Comparisons are unsigned; no wrap is possible given the parameter constraint.

Decomposition:
- Shared header bnn_defs.vh holds:
  - FSM state encodings ST_IDLE=1'b0 and ST_EMIT=1'b1.
  - A default INPUTS/COUNTER_BITS pair shared with popcount instances.
- One sub-module: thermometer_decoder (combinational, count -> INPUTS-bit mask with clamp and overflow outputs).
  - It is instantiated once for the registered thermo and overflow.
  - The serial path uses the idx<n compare, not the mask.
- Bench pairs the block with a popcount instance for round-trip checking.

Test Plan:
- Reset then count=5, count_valid=1, bit_ready=1 -> accept on first post-reset cycle, thermo=8'b00011111, overflow=0, serial 1,1,1,1,1,0,0,0 with bit_last on the 8th bit, IDLE one cycle later.
- count=0 and count=8 -> serial all-0 and all-1 respectively; thermo=8'h00 and 8'hFF; popcount(thermo) equals the count.
- count=13 -> thermo=8'hFF, overflow=1, eight 1s emitted; a following count=2 -> overflow=0, thermo=8'h03.
- count=3 with bit_ready toggling 1,0,0,1,... -> bit_out and bit_last hold during stalls; exactly 8 handshakes; count_ready=0 throughout EMIT; a count_valid pulse mid-EMIT is ignored.
- Reset asserted on the 4th EMIT bit of count=6 -> next cycle bit_valid=0, thermo=0, overflow=0, count_ready=0; count_ready=1 the cycle after reset drops, and a fresh count=1 then emits 1,0,0,0,0,0,0,0.
- Random counts 0..15 back-to-back with random bit_ready, for INPUTS=8 and INPUTS=10/COUNTER_BITS=4 -> sum of serial bits per vector == min(count,INPUTS), popcount(thermo) matches, and each vector takes INPUTS+1 cycles at full ready.

Source files
------------

// File: rtl/unary_expander_pkg.sv
// Shared definitions for the unary expander slice of the binarized datapath.
// Holds the FSM state encoding and the default vector length / count width
// pair that popcount instances elsewhere in the datapath also use.
package unary_expander_pkg;

  // Two-state controller: waiting for a count, or streaming its bits out.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Default geometry; 2**DEFAULT_COUNTER_BITS must exceed DEFAULT_INPUTS.
  localparam int DEFAULT_INPUTS       = 8;
  localparam int DEFAULT_COUNTER_BITS = 4;

endpackage

// File: rtl/unary_expander_thermometer_decoder.sv
// thermometer_decoder: combinational count -> thermometer mask.
// Ports:
//   count    in   COUNTER_BITS  raw count
//   mask     out  INPUTS        mask[i] = (i < clamped)
//   clamped  out  COUNTER_BITS  min(count, INPUTS)
//   overflow out  1             count exceeded INPUTS
module thermometer_decoder
  import unary_expander_pkg::*;
#(
  parameter int INPUTS       = DEFAULT_INPUTS,
  parameter int COUNTER_BITS = DEFAULT_COUNTER_BITS
) (
  input  logic [COUNTER_BITS-1:0] count,
  output logic [INPUTS-1:0]       mask,
  output logic [COUNTER_BITS-1:0] clamped,
  output logic                    overflow
);

  localparam logic [COUNTER_BITS-1:0] LIMIT = COUNTER_BITS'(INPUTS);

  // Clamp the count to the vector length, then light every bit position
  // below the clamped count. The index fits in COUNTER_BITS because the
  // count width is always wide enough to represent INPUTS.
  always_comb begin
    overflow = (count > LIMIT);
    clamped  = overflow ? LIMIT : count;
    mask     = '0;
    for (int i = 0; i < INPUTS; i++) begin
      mask[i] = (COUNTER_BITS'(i) < clamped);
    end
  end

endmodule

// File: rtl/unary_expander.sv
// unary_expander: expands a count into a thermometer-coded vector whose
// popcount equals the clamped count. The vector is offered both as a
// registered parallel word and as an LSB-first serial stream.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   count, count_valid  count to expand and its strobe
//   count_ready         high only while idle (and not in reset)
//   bit_out, bit_valid  serial bit and its strobe (high only while emitting)
//   bit_ready           consumer accepts the current serial bit
//   bit_last            current bit is the final position of the vector
//   thermo              registered mask of the last accepted count
//   overflow            last accepted count was larger than INPUTS
module unary_expander
  import unary_expander_pkg::*;
#(
  parameter int INPUTS       = DEFAULT_INPUTS,
  parameter int COUNTER_BITS = DEFAULT_COUNTER_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COUNTER_BITS-1:0] count,
  input  logic                    count_valid,
  output logic                    count_ready,
  output logic                    bit_out,
  output logic                    bit_valid,
  input  logic                    bit_ready,
  output logic                    bit_last,
  output logic [INPUTS-1:0]       thermo,
  output logic                    overflow
);

  localparam logic [COUNTER_BITS-1:0] LAST_IDX = COUNTER_BITS'(INPUTS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [COUNTER_BITS-1:0] idx;
  logic [COUNTER_BITS-1:0] n;
  logic [INPUTS-1:0]       dec_mask;
  logic [COUNTER_BITS-1:0] dec_clamped;
  logic                    dec_overflow;
  logic                    accept;
  logic                    fire;

  thermometer_decoder #(
    .INPUTS       (INPUTS),
    .COUNTER_BITS (COUNTER_BITS)
  ) u_decoder (
    .count    (count),
    .mask     (dec_mask),
    .clamped  (dec_clamped),
    .overflow (dec_overflow)
  );

  assign accept = count_valid & count_ready;
  assign fire   = bit_valid & bit_ready;

  // State register plus the datapath it controls. A new count loads the
  // clamped length and the parallel word together; thermo and overflow are
  // then left alone until the next accept so the consumer can read them
  // after the stream has finished.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      n        <= '0;
      thermo   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        n        <= dec_clamped;
        thermo   <= dec_mask;
        overflow <= dec_overflow;
        idx      <= '0;
      end else if (fire) begin
        idx <= bit_last ? '0 : idx + 1'b1;
      end
    end
  end

  // Next-state logic: leave idle on an accepted count, return after the
  // final bit of the vector has been handed over.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_EMIT;
      ST_EMIT: if (fire && bit_last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode. The serial bit and last flag come only from registered
  // state, so stalls hold them steady. Readiness is masked by reset so no
  // count is offered while the block is being cleared.
  always_comb begin
    count_ready = 1'b0;
    bit_valid   = 1'b0;
    bit_out     = 1'b0;
    bit_last    = 1'b0;
    case (state)
      ST_IDLE: count_ready = ~reset;
      ST_EMIT: begin
        bit_valid = 1'b1;
        bit_out   = (idx < n);
        bit_last  = (idx == LAST_IDX);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unary_expander.sv
// Self-checking bench for unary_expander. Two instances (8-bit and 10-bit
// vectors) are each compared every cycle against a queue-based model of the
// expected serial stream; directed sequences pin the model with literals.
module tb_unary_expander;

  localparam int INA = 8;
  localparam int INB = 10;
  localparam int CB  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset       = 1'b1;
  logic [CB-1:0] count       = '0;
  logic          count_valid = 1'b0;
  logic          bit_ready   = 1'b0;
  logic          count_ready, bit_out, bit_valid, bit_last, overflow;
  logic [INA-1:0] thermo;

  logic          reset_b       = 1'b1;
  logic [CB-1:0] count_b       = '0;
  logic          count_valid_b = 1'b0;
  logic          bit_ready_b   = 1'b0;
  logic          count_ready_b, bit_out_b, bit_valid_b, bit_last_b, overflow_b;
  logic [INB-1:0] thermo_b;

  int assertCount = 0;
  int failCount   = 0;
  bit doneB       = 1'b0;

  unary_expander #(.INPUTS(INA), .COUNTER_BITS(CB)) dut_a (
    .clk(clk), .reset(reset), .count(count), .count_valid(count_valid),
    .count_ready(count_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .bit_last(bit_last), .thermo(thermo),
    .overflow(overflow)
  );

  unary_expander #(.INPUTS(INB), .COUNTER_BITS(CB)) dut_b (
    .clk(clk), .reset(reset_b), .count(count_b), .count_valid(count_valid_b),
    .count_ready(count_ready_b), .bit_out(bit_out_b), .bit_valid(bit_valid_b),
    .bit_ready(bit_ready_b), .bit_last(bit_last_b), .thermo(thermo_b),
    .overflow(overflow_b)
  );

  function automatic int clampCount(input int c, input int lim);
    return (c > lim) ? lim : c;
  endfunction

  function automatic logic [15:0] thermoOf(input int n);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < n; i++) t[i] = 1'b1;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [CB-1:0] c, input logic v, input logic r);
    count       = c;
    count_valid = v;
    bit_ready   = r;
  endtask

  task automatic sendCount(input logic [CB-1:0] c);
    applyStimulus(c, 1'b1, 1'b1);
    step();
    count_valid = 1'b0;
  endtask

  task automatic drainFull(output logic [INA-1:0] bits);
    bit_ready = 1'b1;
    for (int i = 0; i < INA; i++) begin
      bits[i] = bit_out;
      checkOutput("last_position", bit_last, (i == INA - 1));
      step();
    end
    checkOutput("idle_after_vector", count_ready, 1'b1);
  endtask

  // Reference model A: an accepted count turns into a queue of INA expected
  // bits (ones first); each accepted bit pops one. An empty queue means idle.
  bit             qA[$];
  logic [INA-1:0] thA = '0;
  logic           ovA = 1'b0;
  int             nA  = 0;
  int             sumA = 0;

  initial begin
    logic [15:0] t;
    forever begin
      @(posedge clk);
      if (reset) begin
        qA.delete();
        thA = '0;
        ovA = 1'b0;
      end else if (qA.size() == 0) begin
        if (count_valid) begin
          nA = clampCount(int'(count), INA);
          for (int i = 0; i < INA; i++) qA.push_back(i < nA);
          t   = thermoOf(nA);
          thA = t[INA-1:0];
          ovA = (int'(count) > INA);
        end
      end else if (bit_ready) begin
        void'(qA.pop_front());
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkOutput("a_count_ready", count_ready, (!reset && qA.size() == 0));
      checkOutput("a_bit_valid", bit_valid, (qA.size() != 0));
      checkOutput("a_bit_out", bit_out, (qA.size() != 0) ? qA[0] : 1'b0);
      checkOutput("a_bit_last", bit_last, (qA.size() == 1));
      checkOutput("a_thermo", thermo, thA);
      checkOutput("a_overflow", overflow, ovA);
      if (reset) sumA = 0;
      else if (bit_valid && bit_ready) begin
        sumA += int'(bit_out);
        if (bit_last) begin
          checkOutput("a_roundtrip_serial", sumA, nA);
          checkOutput("a_roundtrip_thermo", $countones(thermo), nA);
          sumA = 0;
        end
      end
    end
  end

  // Reference model B, same rules for the 10-bit instance.
  bit             qB[$];
  logic [INB-1:0] thB = '0;
  logic           ovB = 1'b0;
  int             nB  = 0;
  int             sumB = 0;

  initial begin
    logic [15:0] t;
    forever begin
      @(posedge clk);
      if (reset_b) begin
        qB.delete();
        thB = '0;
        ovB = 1'b0;
      end else if (qB.size() == 0) begin
        if (count_valid_b) begin
          nB = clampCount(int'(count_b), INB);
          for (int i = 0; i < INB; i++) qB.push_back(i < nB);
          t   = thermoOf(nB);
          thB = t[INB-1:0];
          ovB = (int'(count_b) > INB);
        end
      end else if (bit_ready_b) begin
        void'(qB.pop_front());
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkOutput("b_count_ready", count_ready_b, (!reset_b && qB.size() == 0));
      checkOutput("b_bit_valid", bit_valid_b, (qB.size() != 0));
      checkOutput("b_bit_out", bit_out_b, (qB.size() != 0) ? qB[0] : 1'b0);
      checkOutput("b_bit_last", bit_last_b, (qB.size() == 1));
      checkOutput("b_thermo", thermo_b, thB);
      checkOutput("b_overflow", overflow_b, ovB);
      if (reset_b) sumB = 0;
      else if (bit_valid_b && bit_ready_b) begin
        sumB += int'(bit_out_b);
        if (bit_last_b) begin
          checkOutput("b_roundtrip_serial", sumB, nB);
          checkOutput("b_roundtrip_thermo", $countones(thermo_b), nB);
          sumB = 0;
        end
      end
    end
  end

  // Instance B: random traffic, then a full-rate throughput measurement.
  initial begin
    int w;
    int cyc;
    repeat (3) step();
    reset_b = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      count_b       = CB'($urandom_range(0, 15));
      count_valid_b = 1'($urandom_range(0, 1));
      bit_ready_b   = ($urandom_range(0, 3) != 0);
      step();
    end
    count_valid_b = 1'b0;
    bit_ready_b   = 1'b1;
    w = 0;
    while (!count_ready_b && w < 50) begin
      step();
      w++;
    end
    count_b       = 4'd7;
    count_valid_b = 1'b1;
    for (int r = 0; r < 2; r++) begin
      step();
      cyc = 1;
      while (!count_ready_b && cyc < 50) begin
        step();
        cyc++;
      end
      checkOutput("b_throughput", cyc, INB + 1);
    end
    count_valid_b = 1'b0;
    step();
    doneB = 1'b1;
  end

  // Instance A: directed boundary cases, stalls, mid-stream reset, random.
  logic [INA-1:0] bits;
  logic [CB-1:0]  dirCount [4] = '{4'd0, 4'd8, 4'd13, 4'd2};
  logic [INA-1:0] dirThermo[4] = '{8'h00, 8'hFF, 8'hFF, 8'h03};
  logic           dirOvf   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic           stallPat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int cyc;
    int hs;
    int k;
    int w;
    logic prevBit;
    logic prevStall;

    repeat (3) step();
    checkOutput("reset_thermo", thermo, 8'h00);
    checkOutput("reset_bit_valid", bit_valid, 1'b0);
    checkOutput("reset_count_ready", count_ready, 1'b0);
    reset = 1'b0;

    // count = 5 accepted on the first cycle out of reset
    sendCount(4'd5);
    checkOutput("c5_thermo", thermo, 8'b0001_1111);
    checkOutput("c5_overflow", overflow, 1'b0);
    checkOutput("c5_bit_valid", bit_valid, 1'b1);
    drainFull(bits);
    checkOutput("c5_serial", bits, 8'b0001_1111);

    // zero, full, overflow and the overflow-clearing follow-up
    for (int i = 0; i < 4; i++) begin
      sendCount(dirCount[i]);
      checkOutput("dir_thermo", thermo, dirThermo[i]);
      checkOutput("dir_overflow", overflow, dirOvf[i]);
      drainFull(bits);
      checkOutput("dir_serial", bits, dirThermo[i]);
      checkOutput("dir_thermo_held", thermo, dirThermo[i]);
    end

    // back-to-back vectors at full ready take INA+1 cycles each
    applyStimulus(4'd4, 1'b1, 1'b1);
    for (int r = 0; r < 2; r++) begin
      step();
      cyc = 1;
      while (!count_ready && cyc < 50) begin
        step();
        cyc++;
      end
      checkOutput("a_throughput", cyc, INA + 1);
    end
    count_valid = 1'b0;
    step();

    // count = 3 with stalls and an ignored count_valid pulse mid-stream
    sendCount(4'd3);
    hs = 0;
    k = 0;
    prevStall = 1'b0;
    prevBit = 1'b0;
    while (bit_valid && k < 100) begin
      if (prevStall) checkOutput("stall_hold_bit", bit_out, prevBit);
      bit_ready   = stallPat[k % 4];
      count       = 4'd9;
      count_valid = (k == 3);
      checkOutput("emit_count_ready", count_ready, 1'b0);
      if (bit_ready) hs++;
      prevStall = !bit_ready;
      prevBit   = bit_out;
      step();
      k++;
    end
    count_valid = 1'b0;
    checkOutput("stall_handshakes", hs, INA);
    checkOutput("stall_thermo", thermo, 8'h07);
    checkOutput("stall_overflow", overflow, 1'b0);

    // reset on the 4th bit of count = 6 aborts the vector
    sendCount(4'd6);
    repeat (3) step();
    checkOutput("abort_pre_valid", bit_valid, 1'b1);
    reset = 1'b1;
    step();
    checkOutput("abort_bit_valid", bit_valid, 1'b0);
    checkOutput("abort_thermo", thermo, 8'h00);
    checkOutput("abort_overflow", overflow, 1'b0);
    checkOutput("abort_count_ready", count_ready, 1'b0);
    reset = 1'b0;
    step();
    checkOutput("abort_ready_after", count_ready, 1'b1);
    sendCount(4'd1);
    drainFull(bits);
    checkOutput("abort_fresh_serial", bits, 8'h01);

    // random traffic, checked by the per-cycle model
    for (int r = 0; r < 3000; r++) begin
      applyStimulus(CB'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0));
      step();
    end
    applyStimulus(4'd0, 1'b0, 1'b1);
    w = 0;
    while (!count_ready && w < 50) begin
      step();
      w++;
    end
    checkOutput("a_drain_idle", count_ready, 1'b1);

    w = 0;
    while (!doneB && w < 20000) begin
      step();
      w++;
    end
    checkOutput("b_done_timeout", doneB, 1'b1);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
